// File: rtl/hazard_pkg.sv
// Shared types and latency constants for the scoreboard hazard unit.
package hazard_pkg;

  localparam int SB_NREG  = 32;
  localparam int SB_AW    = $clog2(SB_NREG);
  localparam int SB_LAT_W = 3;

  typedef logic [SB_LAT_W-1:0] sb_lat_t;

  localparam sb_lat_t LAT_ALU  = sb_lat_t'(1);
  localparam sb_lat_t LAT_LOAD = sb_lat_t'(2);
  localparam sb_lat_t LAT_MUL  = sb_lat_t'(4);
  localparam sb_lat_t LAT_DIV  = sb_lat_t'(7);

  typedef struct packed {
    logic             v;
    logic [SB_AW-1:0] rd;
  } hist_t;

  localparam hist_t HIST_EMPTY = '{v: 1'b0, rd: '0};

endpackage

// File: rtl/sb_counter.sv
// One scoreboard entry: cycles remaining until a pending result is forwardable.
module sb_counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         clr,
  output logic [W-1:0] cnt,
  output logic         nz
);

  logic [W-1:0] cnt_d, cnt_q;

  // A squash clear beats a new load, which beats the ordinary countdown.
  always_comb begin
    // NOTE: default assignment first so no path through this block infers a latch.
    cnt_d = cnt_q;
    if (clr)                        cnt_d = '0;
    else if (load)                  cnt_d = load_val;
    else if (en && cnt_q != '0)     cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments for all flop updates to avoid race ordering.
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;
  assign nz  = (cnt_q != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Per-register countdown scoreboard: stalls readers and WAW writers until the
// pending result is forwardable, and cancels squashed producers on redirect.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NREG        = SB_NREG,
  parameter int AW          = $clog2(NREG),
  parameter int LAT_W       = SB_LAT_W,
  parameter int NSRC        = 2,
  parameter int FLUSH_DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     issue_valid,
  input  logic                     issue_wen,
  input  logic [AW-1:0]            issue_rd,
  input  logic [LAT_W-1:0]         issue_lat,
  input  logic [NSRC-1:0][AW-1:0]  src_addr,
  input  logic [NSRC-1:0]          src_used,
  input  logic                     hold,
  input  logic                     redirect,
  output logic                     stall_f,
  output logic                     stall_d,
  output logic                     flush_d,
  output logic                     flush_e,
  output logic                     issue_fire,
  output logic [NREG-1:0]          busy_mask
);

  localparam int HD = (FLUSH_DEPTH > 0) ? FLUSH_DEPTH : 1;

  logic [LAT_W-1:0] cnt [NREG];
  logic [LAT_W-1:0] eff_lat;
  logic [NREG-1:0]  clr_vec;
  logic             raw, waw, haz, fire_wr;
  hist_t            hist_d [HD];
  hist_t            hist_q [HD];

  assign eff_lat = (issue_lat == '0) ? LAT_W'(1) : issue_lat;
  assign fire_wr = issue_fire && issue_wen && (issue_rd != '0);

  always_comb begin
    raw = 1'b0;
    for (int s = 0; s < NSRC; s++) begin
      if (src_used[s] && src_addr[s] != '0 && cnt[src_addr[s]] > LAT_W'(1)) raw = 1'b1;
    end
    waw = issue_wen && (issue_rd != '0) && (cnt[issue_rd] > eff_lat);
    haz = issue_valid && (raw || waw);

    stall_f    = 1'b0;
    stall_d    = 1'b0;
    flush_d    = 1'b0;
    flush_e    = 1'b0;
    issue_fire = 1'b0;
    if (redirect) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
    end else if (hold) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
    end else if (haz) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_e = 1'b1;
    end else begin
      issue_fire = issue_valid;
    end
  end

  // Only the youngest FLUSH_DEPTH producers can be wrong-path on a redirect.
  always_comb begin
    clr_vec = '0;
    if (redirect) begin
      for (int i = 0; i < FLUSH_DEPTH; i++) begin
        if (hist_q[i].v) clr_vec[hist_q[i].rd] = 1'b1;
      end
    end
  end

  always_comb begin
    hist_d = hist_q;
    if (redirect) begin
      for (int i = 0; i < HD; i++) hist_d[i] = HIST_EMPTY;
    end else if (!hold) begin
      for (int i = HD - 1; i > 0; i--) hist_d[i] = hist_q[i-1];
      hist_d[0] = '{v: fire_wr, rd: issue_rd};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < HD; i++) hist_q[i] <= HIST_EMPTY;
    end else begin
      hist_q <= hist_d;
    end
  end

  assign cnt[0]       = '0;
  assign busy_mask[0] = 1'b0;

  for (genvar r = 1; r < NREG; r++) begin : g_cnt
    sb_counter #(.W(LAT_W)) u_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (!hold),
      .load     (fire_wr && (issue_rd == AW'(r))),
      .load_val (eff_lat),
      .clr      (clr_vec[r]),
      .cnt      (cnt[r]),
      .nz       (busy_mask[r])
    );
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Randomised and directed bench for hazard_scoreboard against a queue-based model.
module tb_hazard_scoreboard;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            issue_valid, issue_wen, hold, redirect;
  logic [4:0]      issue_rd;
  logic [2:0]      issue_lat;
  logic [1:0][4:0] src_addr;
  logic [1:0]      src_used;
  logic            stall_f, stall_d, flush_d, flush_e, issue_fire;
  logic [31:0]     busy_mask;

  hazard_scoreboard dut (
    .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .issue_wen(issue_wen),
    .issue_rd(issue_rd), .issue_lat(issue_lat), .src_addr(src_addr),
    .src_used(src_used), .hold(hold), .redirect(redirect), .stall_f(stall_f),
    .stall_d(stall_d), .flush_d(flush_d), .flush_e(flush_e),
    .issue_fire(issue_fire), .busy_mask(busy_mask)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Reference model: remaining cycles per register, plus a queue of recent producers.
  typedef struct { bit v; int rd; } mh_t;
  int  m_cnt [32];
  mh_t m_hist [$];
  bit  e_stall, e_fd, e_fe, e_fire;
  bit  o_fire, o_stall;
  int  busy5_cycles;

  task automatic model_reset();
    foreach (m_cnt[r]) m_cnt[r] = 0;
    m_hist = {};
    repeat (2) m_hist.push_back('{v: 0, rd: 0});
  endtask

  function automatic int eff(input int lat);
    return (lat == 0) ? 1 : lat;
  endfunction

  function automatic logic [31:0] model_busy();
    logic [31:0] b = '0;
    for (int r = 1; r < 32; r++) b[r] = (m_cnt[r] != 0);
    return b;
  endfunction

  task automatic model_eval();
    bit raw = 0, waw, haz;
    for (int s = 0; s < 2; s++)
      if (src_used[s] && src_addr[s] != 0 && m_cnt[src_addr[s]] > 1) raw = 1;
    waw = issue_wen && issue_rd != 0 && m_cnt[issue_rd] > eff(int'(issue_lat));
    haz = issue_valid && (raw || waw);
    e_stall = 0; e_fd = 0; e_fe = 0; e_fire = 0;
    if (redirect)  begin e_fd = 1; e_fe = 1; end
    else if (hold) e_stall = 1;
    else if (haz)  begin e_stall = 1; e_fe = 1; end
    else           e_fire = issue_valid;
  endtask

  task automatic model_clock();
    bit wr = e_fire && issue_wen && issue_rd != 0;
    if (!hold) foreach (m_cnt[r]) if (m_cnt[r] > 0) m_cnt[r]--;
    if (wr) m_cnt[issue_rd] = eff(int'(issue_lat));
    if (redirect) begin
      foreach (m_hist[i]) if (m_hist[i].v) m_cnt[m_hist[i].rd] = 0;
      foreach (m_hist[i]) m_hist[i].v = 0;
    end else if (!hold) begin
      m_hist.push_front('{v: wr, rd: int'(issue_rd)});
      void'(m_hist.pop_back());
    end
  endtask

  // Apply one cycle of inputs (called just after a rising edge), check mid-cycle.
  task automatic cyc(input bit v, input bit wen, input int rd, input int lat,
                     input int a0, input int a1, input bit [1:0] used,
                     input bit h, input bit rdr);
    issue_valid = v; issue_wen = wen; issue_rd = 5'(rd); issue_lat = 3'(lat);
    src_addr[0] = 5'(a0); src_addr[1] = 5'(a1); src_used = used;
    hold = h; redirect = rdr;
    @(negedge clk);
    model_eval();
    check("stall_f", stall_f, e_stall);
    check("stall_d", stall_d, e_stall);
    check("flush_d", flush_d, e_fd);
    check("flush_e", flush_e, e_fe);
    check("issue_fire", issue_fire, e_fire);
    check("busy_mask", busy_mask, model_busy());
    o_fire = issue_fire; o_stall = stall_d;
    if (busy_mask[5]) busy5_cycles++;
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
  endtask

  // Re-present one reader until it fires; returns the number of stall cycles.
  task automatic until_fire(input string tag, input bit wen, input int rd, input int lat,
                            input int a0, input int hold_at, output int stalls);
    bit done = 0;
    stalls = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      cyc(1, wen, rd, lat, a0, 1, 2'b11, (i == hold_at), 0);
      if (o_fire) done = 1;
      else if (o_stall) stalls++;
    end
    check({tag, "_fired"}, done, 1'b1);
  endtask

  int st;

  initial begin
    rst_n = 1'b0;
    issue_valid = 0; issue_wen = 0; issue_rd = 0; issue_lat = 0;
    src_addr = '0; src_used = '0; hold = 0; redirect = 0;
    model_reset();
    #12;
    check("rst_stall_d", stall_d, 1'b0);
    check("rst_fire", issue_fire, 1'b0);
    check("rst_busy", busy_mask, 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Load x5 then add x6,x5,x1: one stall, x5 busy for two cycles.
    busy5_cycles = 0;
    cyc(1, 1, 5, 2, 0, 0, 2'b00, 0, 0);
    until_fire("load_use", 1, 6, 1, 5, -1, st);
    check("load_use_stalls", st, 1);
    idle(3);
    check("load_busy5_cycles", busy5_cycles, 2);

    // ALU producer then reader: no stall.
    cyc(1, 1, 7, 1, 0, 0, 2'b00, 0, 0);
    until_fire("alu_use", 1, 12, 1, 7, -1, st);
    check("alu_use_stalls", st, 0);
    idle(2);

    // Mul then reader: three stalls; four with a hold on the second.
    cyc(1, 1, 8, 4, 0, 0, 2'b00, 0, 0);
    until_fire("mul_use", 1, 13, 1, 8, -1, st);
    check("mul_use_stalls", st, 3);
    idle(5);
    cyc(1, 1, 8, 4, 0, 0, 2'b00, 0, 0);
    until_fire("mul_hold", 1, 13, 1, 8, 1, st);
    check("mul_hold_stalls", st, 4);
    idle(5);

    // WAW: ALU write to x9 behind a mul to x9.
    cyc(1, 1, 9, 4, 0, 0, 2'b00, 0, 0);
    until_fire("waw", 1, 9, 1, 0, -1, st);
    check("waw_stalls", st, 3);
    idle(3);

    // Redirect squashes the mul to x10.
    cyc(1, 1, 10, 4, 0, 0, 2'b00, 0, 0);
    cyc(1, 1, 14, 1, 10, 0, 2'b01, 0, 1);
    check("redir_flush_d", flush_d, 1'b1);
    check("redir_busy", busy_mask, 32'h0);
    until_fire("redir_use", 1, 15, 1, 10, -1, st);
    check("redir_use_stalls", st, 0);
    idle(2);

    // x0 writes and x0 reads never stall.
    cyc(1, 1, 0, 7, 0, 0, 2'b11, 0, 0);
    until_fire("x0", 1, 0, 7, 0, -1, st);
    check("x0_stalls", st, 0);
    check("x0_busy", busy_mask, 32'h0);

    // Reset in the middle of a long stall.
    cyc(1, 1, 11, 7, 0, 0, 2'b00, 0, 0);
    cyc(1, 1, 16, 1, 11, 0, 2'b01, 0, 0);
    check("pre_rst_stall", o_stall, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_stall_d", stall_d, 1'b0);
    check("midrst_busy", busy_mask, 32'h0);
    model_reset();
    @(posedge clk); #1 rst_n = 1'b1;
    idle(2);

    // Random traffic on a small register window to provoke every hazard kind.
    for (int n = 0; n < 3000; n++) begin
      cyc($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 7,
          $urandom_range(0, 7), $urandom_range(0, 7),
          $urandom_range(0, 7), $urandom_range(0, 7), 2'($urandom_range(0, 3)),
          $urandom_range(0, 9) < 2, $urandom_range(0, 9) < 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
